uart_tx_frame_ctrl: RTL and testbench

Transmit-side frame sequencer for the UART. It accepts one data byte per valid/ready handshake and serialises it LSB-first as start, data, optional parity and stop bits. Each bit is held for CLKS_PER_BIT clocks. It drives the tx line directly and reports frame completion to the upstream TX buffer.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_tx_frame_ctrl_bit_timer.sv | 44 ++++
 rtl/uart_tx_frame_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit and receive paths.
//   parity_t      - line parity selection as carried on the parity_type ports
//   tx_state_t    - frame sequencer states of uart_tx_frame_ctrl
//   parity_calc   - parity bit for a data word under a given parity_t
//   parity_enabled- whether a parity_t inserts a parity bit into the frame
package uart_pkg;

  // Widest data word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PARITY_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    NOPARITY00 = 2'b00,
    ODD        = 2'b01,
    EVEN       = 2'b10,
    NOPARITY11 = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // EVEN sends the plain XOR of the data, ODD its complement; no-parity types yield 0.
  function automatic logic parity_calc(input logic [PARITY_MAX_WIDTH-1:0] data,
                                       input parity_t ptype);
    logic result;
    case (ptype)
      EVEN:    result = ^data;
      ODD:     result = ~^data;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic parity_enabled(input parity_t ptype);
    logic result;
    case (ptype)
      EVEN:    result = 1'b1;
      ODD:     result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_bit_timer.sv
// uart_bit_timer: clocks-within-bit down-counter for the UART transmitter.
//   clock        - system clock
//   reset        - synchronous active-high reset, clears the counter
//   restart      - load a full bit period (first cycle of a frame follows)
//   enable       - frame in progress; counter idles at 0 otherwise
//   bit_end      - high during the last clock of the current bit
//   bit_near_end - high during the second-to-last clock of the current bit
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_end,
  output logic bit_near_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Count down through each bit period and reload at every bit boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= {CW{1'b0}};
    end else if (restart) begin
      count <= RELOAD;
    end else if (enable) begin
      if (count == {CW{1'b0}}) begin
        count <= RELOAD;
      end else begin
        count <= count - CW'(1);
      end
    end else begin
      count <= {CW{1'b0}};
    end
  end

  assign bit_end      = (count == {CW{1'b0}});
  assign bit_near_end = (count == CW'(1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART transmit frame sequencer.
// Accepts a byte on a valid/ready handshake and shifts it out LSB-first as
// start, data, optional parity and one or two stop bits, each CLKS_PER_BIT clocks.
//   clock       - system clock, rising edge
//   reset       - synchronous active-high reset
//   tx_data     - byte to send, sampled on handshake
//   tx_valid    - upstream has a byte
//   tx_ready    - controller can accept a byte (IDLE only)
//   parity_type - parity_t encoding, sampled on handshake
//   stop_bits   - 0: one stop bit, 1: two stop bits, sampled on handshake
//   tx          - registered serial line, idle high
//   tx_busy     - frame in progress
//   tx_done     - one-cycle pulse in the final clock of the last stop bit
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
  logic                  par_bit, par_bit_nxt;
  logic                  par_en, par_en_nxt;
  logic                  two_stop, two_stop_nxt;
  logic                  stop_cnt, stop_cnt_nxt;
  logic                  tx_nxt, ready_nxt, busy_nxt, done_nxt;
  logic                  handshake, bit_end, bit_near_end;
  logic                  last_stop;

  assign handshake = tx_valid & tx_ready;
  assign last_stop = (stop_cnt == two_stop);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock       (clock),
    .reset       (reset),
    .restart     (handshake),
    .enable      (tx_busy),
    .bit_end     (bit_end),
    .bit_near_end(bit_near_end)
  );

  // Next-state and next-output logic; outputs are computed one clock ahead so
  // that tx and the status flags come straight from flops.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    par_bit_nxt  = par_bit;
    par_en_nxt   = par_en;
    two_stop_nxt = two_stop;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx;
    ready_nxt    = 1'b0;
    busy_nxt     = 1'b1;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (handshake) begin
          // Parity is resolved now so later parity_type changes cannot leak in.
          state_nxt    = ST_START;
          shift_nxt    = tx_data;
          par_bit_nxt  = parity_calc(PARITY_MAX_WIDTH'(tx_data), parity_t'(parity_type));
          par_en_nxt   = parity_enabled(parity_t'(parity_type));
          two_stop_nxt = stop_bits;
          bit_idx_nxt  = {IDX_W{1'b0}};
          stop_cnt_nxt = 1'b0;
          tx_nxt       = 1'b0;
          ready_nxt    = 1'b0;
          busy_nxt     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = {IDX_W{1'b0}};
          tx_nxt      = shift[0];
        end else begin
          state_nxt = ST_START;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            if (par_en) begin
              state_nxt = ST_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt    = ST_STOP;
              stop_cnt_nxt = 1'b0;
              tx_nxt       = 1'b1;
            end
          end else begin
            // The shifter keeps the bit being sent at position 0.
            bit_idx_nxt = bit_idx + IDX_W'(1);
            shift_nxt   = {1'b0, shift[DATA_WIDTH-1:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_nxt    = ST_STOP;
          stop_cnt_nxt = 1'b0;
          tx_nxt       = 1'b1;
        end else begin
          state_nxt = ST_PARITY;
        end
      end

      ST_STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          if (last_stop) begin
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end else if (bit_near_end && last_stop) begin
          // Registered pulse lands on the final clock of the last stop bit.
          done_nxt = 1'b1;
        end else begin
          state_nxt = ST_STOP;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, frame context and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift    <= {DATA_WIDTH{1'b0}};
      bit_idx  <= {IDX_W{1'b0}};
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      par_bit  <= par_bit_nxt;
      par_en   <= par_en_nxt;
      two_stop <= two_stop_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx       <= tx_nxt;
      tx_ready <= ready_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl with CLKS_PER_BIT=4, DATA_WIDTH=8.
// Expected per-clock tx values are queued when a byte is handed over and
// popped while the frame is on the line.
module tb_uart_tx_frame_ctrl;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    parity_type;
  logic          stop_bits;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  uart_tx_frame_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_type(parity_type),
    .stop_bits  (stop_bits),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Queue one tx value per clock for a whole frame; returns the frame length in clocks.
  task automatic push_frame(input logic [DW-1:0] d, input logic [1:0] p, input logic s,
                            output int cycles);
    logic bits[$];
    int   ones;
    logic par;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p == 2'b01 || p == 2'b10) begin
      par = ones[0];
      if (p == 2'b01) par = ~par;
      bits.push_back(par);
    end
    bits.push_back(1'b1);
    if (s) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[k]);
    end
    cycles = CPB * bits.size();
  endtask

  // Present a byte, wait (bounded) for ready, and complete the handshake edge.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] p, input logic s,
                      input bit keep, output int cycles);
    int guard;
    guard = 0;
    @(negedge clock);
    tx_data     = d;
    parity_type = p;
    stop_bits   = s;
    tx_valid    = 1'b1;
    while (tx_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("ready_before_handshake", tx_ready, 1'b1);
    push_frame(d, p, s, cycles);
    @(posedge clock);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  // Check frame clocks first..last (clock 1 is the first start-bit clock).
  task automatic check_cycles(input string tag, input int first, input int last,
                              input int frame_len);
    logic e;
    for (int c = first; c <= last; c++) begin
      @(negedge clock);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      chk($sformatf("%s_tx_c%0d", tag, c), tx, e);
      chk($sformatf("%s_done_c%0d", tag, c), tx_done, (c == frame_len));
      chk($sformatf("%s_busy_c%0d", tag, c), tx_busy, 1'b1);
      chk($sformatf("%s_ready_c%0d", tag, c), tx_ready, 1'b0);
    end
  endtask

  // The clock after the last stop bit must be idle with ready back.
  task automatic check_idle(input string tag);
    @(negedge clock);
    chk({tag, "_idle_ready"}, tx_ready, 1'b1);
    chk({tag, "_idle_busy"}, tx_busy, 1'b0);
    chk({tag, "_idle_tx"}, tx, 1'b1);
    chk({tag, "_idle_done"}, tx_done, 1'b0);
  endtask

  initial begin
    int n, n2;
    reset       = 1'b1;
    tx_valid    = 1'b1;
    tx_data     = 8'h55;
    parity_type = 2'b10;
    stop_bits   = 1'b0;

    // Reset with valid asserted.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", tx_ready, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_done", tx_done, 1'b0);
    reset    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clock);
    chk("post_reset_busy", tx_busy, 1'b0);
    chk("post_reset_tx", tx, 1'b1);

    // Even parity, one stop bit.
    send(8'h17, 2'b10, 1'b0, 1'b0, n);
    check_cycles("even17", 1, n, n);
    check_idle("even17");

    // Odd parity variants.
    send(8'hAF, 2'b01, 1'b0, 1'b0, n);
    check_cycles("oddAF", 1, n, n);
    check_idle("oddAF");
    send(8'hA9, 2'b01, 1'b1, 1'b0, n);
    check_cycles("oddA9s2", 1, n, n);
    check_idle("oddA9s2");

    // No parity, both encodings.
    send(8'h0F, 2'b00, 1'b0, 1'b0, n);
    check_cycles("np00", 1, n, n);
    check_idle("np00");
    send(8'h0F, 2'b11, 1'b0, 1'b0, n);
    check_cycles("np11", 1, n, n);
    check_idle("np11");

    // Back-to-back with valid held high and inputs changing mid-frame.
    send(8'h17, 2'b10, 1'b0, 1'b1, n);
    check_cycles("b2b1", 1, 10, n);
    parity_type = 2'b00;
    tx_data     = 8'h00;
    stop_bits   = 1'b1;
    check_cycles("b2b1", 11, 30, n);
    tx_data     = 8'hBD;
    parity_type = 2'b01;
    stop_bits   = 1'b0;
    check_cycles("b2b1", 31, n, n);
    @(negedge clock);
    chk("b2b_gap_ready", tx_ready, 1'b1);
    chk("b2b_gap_tx", tx, 1'b1);
    chk("b2b_gap_busy", tx_busy, 1'b0);
    push_frame(8'hBD, 2'b01, 1'b0, n2);
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    check_cycles("b2b2", 1, n2, n2);
    check_idle("b2b2");

    // Reset during data bit 3 abandons the frame.
    send(8'hA9, 2'b01, 1'b0, 1'b0, n);
    check_cycles("midrst", 1, 18, n);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_ready", tx_ready, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_done", tx_done, 1'b0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_after_done", tx_done, 1'b0);
    chk("midrst_after_busy", tx_busy, 1'b0);
    send(8'h3C, 2'b10, 1'b1, 1'b0, n);
    check_cycles("recover", 1, n, n);
    check_idle("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
